and2_checker: RTL and testbench
===============================

AND2_CHECKER -- requirements
Module: and2_checker

Interface
REQ-001 SHALL have parameter SETTLE, default 1, meaning cycles each vector is held before y is sampled (legal range 1..15).
REQ-002 SHALL have parameter ITER, default 1, meaning number of full 4-vector sweeps per run (legal range 1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  run request, sampled only in IDLE.
REQ-006 SHALL have port a_o  output  1  operand a driven to the and2 DUT side of the interface.
REQ-007 SHALL have port b_o  output  1  operand b driven to the and2 DUT side of the interface.
REQ-008 SHALL have port y_i  input  1  DUT result returned over the interface.
REQ-009 SHALL have port busy  output  1  high while a run is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at run end.
REQ-011 SHALL have port pass  output  1  sticky result of the last completed run: 1 = no mismatches.
REQ-012 SHALL have port err_cnt  output  8  mismatch count of the current or last run.

Function
REQ-013 SHALL implement FSM states IDLE, DRIVE, CHECK, DONE.
REQ-014 IDLE: start=1 -> DRIVE; clear err_cnt and pass; load vector index 0 and sweep 0.
REQ-015 DRIVE: a_o/b_o SHALL be registered from vector index, in order 00, 01, 10, 11 (a_o = MSB).
REQ-016 DRIVE SHALL last exactly SETTLE cycles, counted by a settle counter; then -> CHECK.
REQ-017 CHECK SHALL last one cycle and compare y_i against a_o AND b_o; a mismatch increments err_cnt.
REQ-018 err_cnt SHALL saturate at 255 and never wrap.
REQ-019 After CHECK, SHALL advance to the next vector -> DRIVE; after vector 11, the sweep counter SHALL increment and the vector index SHALL wrap to 00.
REQ-020 After CHECK of vector 11 in sweep ITER-1, SHALL go -> DONE.
REQ-021 DONE SHALL last one cycle: done=1, pass=(err_cnt==0, including a mismatch found in that final CHECK); then -> IDLE.
REQ-022 busy SHALL be 1 in DRIVE, CHECK and DONE, and 0 in IDLE.
REQ-023 done SHALL pulse exactly 4*ITER*(SETTLE+1)+1 cycles after the edge that samples start.
REQ-024 start asserted while busy SHALL be ignored and SHALL NOT be queued.
REQ-025 In IDLE, a_o/b_o SHALL be 0; pass and err_cnt SHALL hold their last-run values.
REQ-026 A start held high continuously SHALL launch a new run on the first IDLE cycle after DONE.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, a_o=0, b_o=0, busy=0, done=0, pass=0, err_cnt=0, with all counters at 0, regardless of clk.
REQ-028 Reset mid-run SHALL abort the run without a done pulse; the first run after reset release SHALL require a fresh start.

Structure
REQ-029 Package and2_chk_pkg SHALL hold the state enum, the NUM_VEC=4 constant and the err_cnt width constant.
REQ-030 SHALL contain a single sub-module, sat_cnt (saturating 8-bit up-counter with clear), used for err_cnt.
REQ-031 SHALL connect to the DUT through the tb-side modport of and2_intf (the counterpart of the dut modport).

Verification
REQ-032 SETTLE=1, ITER=1, correct AND DUT, start pulse -> done at cycle 9, pass=1, err_cnt=0.
REQ-033 y_i stuck at 0 -> err_cnt=1 (vector 11 only), pass=0.
REQ-034 y_i stuck at 1, ITER=2 -> err_cnt=6, pass=0, done at cycle 17.
REQ-035 Reset asserted in the CHECK of vector 10 -> outputs zero within the same cycle, no done pulse, restart run gives pass=1.
REQ-036 start re-pulsed at cycles 3 and 5 of a run -> ignored, exactly one done pulse.
REQ-037 y_i stuck at 1, ITER=255 -> err_cnt saturates at 255 with no wrap.

Source files
------------

// File: rtl/and2_chk_pkg.sv
// Shared types and constants for the and2 exhaustive checker.
package and2_chk_pkg;

  // Number of input vectors in one sweep of a two-input gate.
  localparam int NUM_VEC  = 4;
  localparam int VEC_W    = 2;

  // Width of the mismatch counter.
  localparam int ERR_W    = 8;

  // Counter widths sized for the legal parameter ranges (SETTLE 1..15, ITER 1..255).
  localparam int SETTLE_W = 4;
  localparam int SWEEP_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Golden reference for the gate under test.
  function automatic logic expected_y(input logic a, input logic b);
    return a & b;
  endfunction

endpackage

// File: rtl/and2_intf.sv
// Signal bundle between the checker and an and2 gate.
// The dut modport is the gate's view; the tb modport is the checker's view.
interface and2_intf;
  logic a;
  logic b;
  logic y;

  modport dut (input a, input b, output y);
  modport tb  (output a, output b, input y);
endinterface

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_cnt
  import and2_chk_pkg::*;
#(
  parameter int W = ERR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Clear has priority over increment; increment stops at the maximum value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/and2_checker.sv
// Exhaustive checker for a two-input AND gate.
// Each run drives the four vectors 00,01,10,11 ITER times, holds each vector
// for SETTLE cycles, then spends one cycle comparing the returned y against
// the golden AND. Mismatches are counted (saturating) and summarised in pass.
module and2_checker
  import and2_chk_pkg::*;
#(
  parameter int SETTLE = 1,
  parameter int ITER   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a_o,
  output logic             b_o,
  input  logic             y_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);
  localparam logic [SWEEP_W-1:0]  ITER_LAST   = SWEEP_W'(ITER - 1);
  localparam logic [VEC_W-1:0]    VEC_LAST    = VEC_W'(NUM_VEC - 1);

  state_t               state_q;
  state_t               state_d;
  logic [SETTLE_W-1:0]  settle_q;
  logic [VEC_W-1:0]     vec_q;
  logic [SWEEP_W-1:0]   sweep_q;
  logic                 a_q;
  logic                 b_q;
  logic                 pass_q;

  logic                 launch;
  logic                 settle_done;
  logic                 last_vec;
  logic                 last_sweep;
  logic                 mismatch;
  logic                 run_end;
  logic [VEC_W-1:0]     vec_nxt;

  // Checker-side view of the gate connection: operands out, result in.
  and2_intf bus ();
  assign bus.a = a_q;
  assign bus.b = b_q;
  assign bus.y = y_i;

  assign launch      = (state_q == IDLE) && start;
  assign settle_done = (settle_q == SETTLE_LAST);
  assign last_vec    = (vec_q == VEC_LAST);
  assign last_sweep  = (sweep_q == ITER_LAST);
  assign run_end     = (state_q == CHECK) && last_vec && last_sweep;
  assign mismatch    = (state_q == CHECK) && (bus.y != expected_y(bus.a, bus.b));
  assign vec_nxt     = last_vec ? '0 : vec_q + 1'b1;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      // NOTE: non-blocking assignment in clocked blocks so every register
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only looked at in IDLE, so it cannot queue.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = DRIVE;
      DRIVE:   if (settle_done) state_d = CHECK;
      CHECK:   state_d = run_end ? DONE : DRIVE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sequencing counters, registered operands and the sticky pass flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_q <= '0;
      vec_q    <= '0;
      sweep_q  <= '0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (launch) begin
            settle_q <= '0;
            vec_q    <= '0;
            sweep_q  <= '0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            pass_q   <= 1'b0;
          end
        end
        DRIVE: begin
          settle_q <= settle_done ? '0 : settle_q + 1'b1;
        end
        CHECK: begin
          if (run_end) begin
            // Operands return to zero; pass must include this final compare.
            a_q    <= 1'b0;
            b_q    <= 1'b0;
            pass_q <= (err_cnt == '0) && !mismatch;
          end else begin
            vec_q <= vec_nxt;
            a_q   <= vec_nxt[1];
            b_q   <= vec_nxt[0];
            if (last_vec) begin
              sweep_q <= sweep_q + 1'b1;
            end
          end
        end
        DONE: begin
          a_q <= 1'b0;
          b_q <= 1'b0;
        end
        default: begin
          settle_q <= '0;
        end
      endcase
    end
  end

  // Mismatch counter: cleared on launch, bumped on each failing compare.
  sat_cnt #(
    .W(ERR_W)
  ) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (launch),
    .inc (mismatch),
    .cnt (err_cnt)
  );

  assign a_o  = bus.a;
  assign b_o  = bus.b;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign pass = pass_q;

endmodule

// File: tb/tb_and2_checker.sv
// Directed self-checking bench for and2_checker.
// Cycle numbering: cycle 1 starts at the clock edge that samples start.
module tb_and2_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_r [3];
  logic       y_r     [3];
  logic       a_w     [3];
  logic       b_w     [3];
  logic       busy_w  [3];
  logic       done_w  [3];
  logic       pass_w  [3];
  logic [7:0] err_w   [3];
  int         mode    [3];   // 0 = correct AND, 1 = stuck at 0, 2 = stuck at 1

  int         checks = 0;
  int         errors = 0;
  logic [1:0] ab_log [0:63];
  int         cyc;
  int         pulses;
  int         cnt;

  always #5 clk = ~clk;

  function automatic logic gate_y(input int m, input logic a, input logic b);
    case (m)
      1:       return 1'b0;
      2:       return 1'b1;
      default: return a & b;
    endcase
  endfunction

  assign y_r[0] = gate_y(mode[0], a_w[0], b_w[0]);
  assign y_r[1] = gate_y(mode[1], a_w[1], b_w[1]);
  assign y_r[2] = gate_y(mode[2], a_w[2], b_w[2]);

  and2_checker #(.SETTLE(1), .ITER(1)) u0 (
    .clk(clk), .rst(rst), .start(start_r[0]), .a_o(a_w[0]), .b_o(b_w[0]),
    .y_i(y_r[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_cnt(err_w[0])
  );

  and2_checker #(.SETTLE(1), .ITER(2)) u1 (
    .clk(clk), .rst(rst), .start(start_r[1]), .a_o(a_w[1]), .b_o(b_w[1]),
    .y_i(y_r[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_cnt(err_w[1])
  );

  and2_checker #(.SETTLE(1), .ITER(255)) u2 (
    .clk(clk), .rst(rst), .start(start_r[2]), .a_o(a_w[2]), .b_o(b_w[2]),
    .y_i(y_r[2]), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .err_cnt(err_w[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start on instance d and follow the run until one cycle past the
  // first done. hold keeps start high throughout; repulse re-asserts it in
  // cycles 3 and 5. Returns the cycle of the first done and the pulse count.
  task automatic run(input int d, input int budget, input bit hold, input bit repulse,
                     output int done_cyc, output int npulse);
    int n;
    done_cyc = 0;
    npulse   = 0;
    start_r[d] = 1'b1;
    tick();
    n = 1;
    while (n <= budget) begin
      start_r[d] = hold || (repulse && (n == 3 || n == 5));
      if (n < 64) ab_log[n] = {a_w[d], b_w[d]};
      if (done_w[d]) begin
        npulse++;
        if (done_cyc == 0) done_cyc = n;
      end
      if (done_cyc != 0 && n == done_cyc + 1) break;
      tick();
      n++;
    end
    if (!hold) start_r[d] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_r[i] = 1'b0;
      mode[i]    = 0;
    end
    tick();
    tick();

    // Reset values.
    check("rst_busy", busy_w[0], 0);
    check("rst_done", done_w[0], 0);
    check("rst_pass", pass_w[0], 0);
    check("rst_err",  err_w[0],  0);
    check("rst_a",    a_w[0],    0);
    check("rst_b",    b_w[0],    0);
    rst = 1'b0;
    tick();
    check("idle_no_start_busy", busy_w[0], 0);

    // Correct gate, single sweep.
    run(0, 40, 1'b0, 1'b0, cyc, pulses);
    check("ok_done_cycle", cyc, 9);
    check("ok_pulses", pulses, 1);
    check("ok_pass", pass_w[0], 1);
    check("ok_err", err_w[0], 0);
    check("ok_idle_busy", busy_w[0], 0);
    check("ok_idle_a", a_w[0], 0);
    check("ok_idle_b", b_w[0], 0);
    for (int n = 1; n <= 8; n++) begin
      check($sformatf("ab_cycle%0d", n), ab_log[n], (n - 1) / 2);
    end

    // Gate stuck at 0: only vector 11 mismatches.
    mode[0] = 1;
    run(0, 40, 1'b0, 1'b0, cyc, pulses);
    check("s0_done_cycle", cyc, 9);
    check("s0_err", err_w[0], 1);
    check("s0_pass", pass_w[0], 0);
    repeat (3) tick();
    check("s0_err_held", err_w[0], 1);
    check("s0_pass_held", pass_w[0], 0);

    // Gate stuck at 1 over two sweeps: three mismatches per sweep.
    mode[1] = 2;
    run(1, 60, 1'b0, 1'b0, cyc, pulses);
    check("s1_done_cycle", cyc, 17);
    check("s1_err", err_w[1], 6);
    check("s1_pass", pass_w[1], 0);

    // Start held high: new run launches from the first IDLE cycle after DONE.
    mode[0] = 0;
    run(0, 40, 1'b1, 1'b0, cyc, pulses);
    check("hold_done_cycle", cyc, 9);
    check("hold_err_cleared", err_w[0], 0);
    check("hold_idle_gap", busy_w[0], 0);
    tick();
    check("hold_relaunch", busy_w[0], 1);
    start_r[0] = 1'b0;
    cnt = 0;
    while (busy_w[0] && cnt < 40) begin
      tick();
      cnt++;
    end
    check("hold_drain", busy_w[0], 0);

    // Start re-pulsed mid-run: ignored, not queued.
    run(0, 40, 1'b0, 1'b1, cyc, pulses);
    check("rep_done_cycle", cyc, 9);
    check("rep_pulses", pulses, 1);
    tick();
    check("rep_not_queued", busy_w[0], 0);

    // Reset during the CHECK of vector 10 (cycle 6).
    mode[0] = 2;
    start_r[0] = 1'b1;
    tick();
    start_r[0] = 1'b0;
    repeat (5) tick();
    check("mid_a", a_w[0], 1);
    check("mid_b", b_w[0], 0);
    check("mid_err", err_w[0], 2);
    rst = 1'b1;
    #1;
    check("arst_busy", busy_w[0], 0);
    check("arst_a", a_w[0], 0);
    check("arst_err", err_w[0], 0);
    check("arst_pass", pass_w[0], 0);
    tick();
    tick();
    rst = 1'b0;
    mode[0] = 0;
    pulses = 0;
    cnt = 0;
    for (int n = 0; n < 15; n++) begin
      if (done_w[0]) pulses++;
      if (busy_w[0]) cnt++;
      tick();
    end
    check("arst_no_done", pulses, 0);
    check("arst_no_autorun", cnt, 0);
    run(0, 40, 1'b0, 1'b0, cyc, pulses);
    check("restart_done_cycle", cyc, 9);
    check("restart_pass", pass_w[0], 1);
    check("restart_err", err_w[0], 0);

    // Gate stuck at 1 over 255 sweeps: 765 mismatches saturate at 255.
    mode[2] = 2;
    run(2, 3000, 1'b0, 1'b0, cyc, pulses);
    check("sat_done_cycle", cyc, 2041);
    check("sat_err", err_w[2], 255);
    check("sat_pass", pass_w[2], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
